// File: rtl/pipeline_stage_decode.sv
// rtl/pipeline_stage_decode.sv - decode stage: field decode, bypassed register file, load-use stall, wrong-path squash
// Define PIPELINE_DECODE_STATS_EN to add the saturating stallCount/squashCount ports.
module pipeline_stage_decode #(
  parameter int REG_COUNT  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        fetchProgramCounter,
  input  logic                         fetchChangedTimes,
  input  logic [DATA_WIDTH-1:0]        fetchInstruction,
  input  logic                         jumpEnabled,
  input  logic                         writeEnable,
  input  logic [$clog2(REG_COUNT)-1:0] writeIndex,
  input  logic [DATA_WIDTH-1:0]        writeValue,
  output logic                         stallOnDecode,
  output logic                         decValid,
  output logic [DATA_WIDTH-1:0]        decProgramCounter,
  output logic [DATA_WIDTH-1:0]        decRsValue,
  output logic [DATA_WIDTH-1:0]        decRtValue,
  output logic [DATA_WIDTH-1:0]        decImmediate,
  output logic [$clog2(REG_COUNT)-1:0] decDestIndex,
  output logic [5:0]                   decOpcode,
  output logic [5:0]                   decFunct,
  output logic                         decMemRead,
  output logic                         decMemWrite,
  output logic                         decRegWrite
`ifdef PIPELINE_DECODE_STATS_EN
  ,
  output logic [31:0]                  stallCount,
  output logic [31:0]                  squashCount
`endif
);

  localparam int IDX_W = $clog2(REG_COUNT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  logic [DATA_WIDTH-1:0] regFile [REG_COUNT];

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [IDX_W-1:0]      rsIdx;
  logic [IDX_W-1:0]      rtIdx;
  logic [IDX_W-1:0]      rdIdx;
  logic [15:0]           imm16;

  logic [DATA_WIDTH-1:0] immediate;
  logic [IDX_W-1:0]      destIndex;
  logic                  memRead;
  logic                  memWrite;
  logic                  regWrite;
  logic                  usesRt;

  logic [DATA_WIDTH-1:0] rsValue;
  logic [DATA_WIDTH-1:0] rtValue;

  logic                  expectedToggle;
  logic                  primed;
  logic                  onPath;
  logic                  live;
  logic                  hazard;

  assign opcode = fetchInstruction[31:26];
  assign funct  = fetchInstruction[5:0];
  assign rsIdx  = IDX_W'(fetchInstruction[25:21]);
  assign rtIdx  = IDX_W'(fetchInstruction[20:16]);
  assign rdIdx  = IDX_W'(fetchInstruction[15:11]);
  assign imm16  = fetchInstruction[15:0];

  always_comb begin
    immediate = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    destIndex = '0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    usesRt    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        destIndex = rdIdx;
        usesRt    = 1'b1;
      end
      OP_LW: begin
        destIndex = rtIdx;
        memRead   = 1'b1;
      end
      OP_SW: begin
        memWrite  = 1'b1;
        usesRt    = 1'b1;
      end
      OP_ADDI: destIndex = rtIdx;
      OP_ANDI, OP_ORI: begin
        destIndex = rtIdx;
        immediate = {{(DATA_WIDTH-16){1'b0}}, imm16};
      end
      OP_LUI: begin
        destIndex = rtIdx;
        immediate = {imm16, {(DATA_WIDTH-16){1'b0}}};
      end
      OP_BEQ:  usesRt = 1'b1;
      OP_J:    immediate = {{(DATA_WIDTH-26){1'b0}}, fetchInstruction[25:0]};
      default: ;
    endcase
  end

  // Register 0 is never a real destination, so it never asks for a write.
  assign regWrite = (destIndex != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeEnable && writeIndex != '0) begin
      regFile[writeIndex] <= writeValue;
    end
  end

  // Same-cycle writeback is forwarded so decode never reads a stale value.
  always_comb begin
    rsValue = '0;
    if (rsIdx != '0) begin
      if (writeEnable && writeIndex == rsIdx) rsValue = writeValue;
      else                                    rsValue = regFile[rsIdx];
    end
  end

  always_comb begin
    rtValue = '0;
    if (rtIdx != '0) begin
      if (writeEnable && writeIndex == rtIdx) rtValue = writeValue;
      else                                    rtValue = regFile[rtIdx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      expectedToggle <= 1'b0;
      primed         <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (jumpEnabled) expectedToggle <= ~expectedToggle;
    end
  end

  assign onPath = (fetchChangedTimes == expectedToggle);
  assign live   = primed && onPath && !jumpEnabled;

  // Only a load still sitting in the execute input can cause a stall; one cycle later MEM forwards it.
  assign hazard = live && decValid && decMemRead && (decDestIndex != '0) &&
                  ((decDestIndex == rsIdx) || (usesRt && decDestIndex == rtIdx));

  assign stallOnDecode = hazard && !reset;

  always_ff @(posedge clock) begin
    if (reset || !live || hazard) begin
      decValid          <= 1'b0;
      decProgramCounter <= '0;
      decRsValue        <= '0;
      decRtValue        <= '0;
      decImmediate      <= '0;
      decDestIndex      <= '0;
      decOpcode         <= '0;
      decFunct          <= '0;
      decMemRead        <= 1'b0;
      decMemWrite       <= 1'b0;
      decRegWrite       <= 1'b0;
    end else begin
      decValid          <= 1'b1;
      decProgramCounter <= fetchProgramCounter;
      decRsValue        <= rsValue;
      decRtValue        <= rtValue;
      decImmediate      <= immediate;
      decDestIndex      <= destIndex;
      decOpcode         <= opcode;
      decFunct          <= funct;
      decMemRead        <= memRead;
      decMemWrite       <= memWrite;
      decRegWrite       <= regWrite;
    end
  end

`ifdef PIPELINE_DECODE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stallCount  <= '0;
      squashCount <= '0;
    end else begin
      if (hazard && stallCount != '1) stallCount <= stallCount + 32'd1;
      if (((primed && !onPath) || jumpEnabled) && squashCount != '1) squashCount <= squashCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_decode.sv
// tb/tb_pipeline_stage_decode.sv - scoreboard bench for the decode stage
// Build with PIPELINE_DECODE_STATS_EN defined to also exercise the statistics counters.
module tb_pipeline_stage_decode;

  logic        clock;
  logic        reset;
  logic [31:0] fetchProgramCounter;
  logic        fetchChangedTimes;
  logic [31:0] fetchInstruction;
  logic        jumpEnabled;
  logic        writeEnable;
  logic [4:0]  writeIndex;
  logic [31:0] writeValue;
  logic        stallOnDecode;
  logic        decValid;
  logic [31:0] decProgramCounter;
  logic [31:0] decRsValue;
  logic [31:0] decRtValue;
  logic [31:0] decImmediate;
  logic [4:0]  decDestIndex;
  logic [5:0]  decOpcode;
  logic [5:0]  decFunct;
  logic        decMemRead;
  logic        decMemWrite;
  logic        decRegWrite;
`ifdef PIPELINE_DECODE_STATS_EN
  logic [31:0] stallCount;
  logic [31:0] squashCount;
`endif

  pipeline_stage_decode dut (
    .clock               (clock),
    .reset               (reset),
    .fetchProgramCounter (fetchProgramCounter),
    .fetchChangedTimes   (fetchChangedTimes),
    .fetchInstruction    (fetchInstruction),
    .jumpEnabled         (jumpEnabled),
    .writeEnable         (writeEnable),
    .writeIndex          (writeIndex),
    .writeValue          (writeValue),
    .stallOnDecode       (stallOnDecode),
    .decValid            (decValid),
    .decProgramCounter   (decProgramCounter),
    .decRsValue          (decRsValue),
    .decRtValue          (decRtValue),
    .decImmediate        (decImmediate),
    .decDestIndex        (decDestIndex),
    .decOpcode           (decOpcode),
    .decFunct            (decFunct),
    .decMemRead          (decMemRead),
    .decMemWrite         (decMemWrite),
    .decRegWrite         (decRegWrite)
`ifdef PIPELINE_DECODE_STATS_EN
    ,
    .stallCount          (stallCount),
    .squashCount         (squashCount)
`endif
  );

  localparam logic [31:0] I_ADDI_R1_5   = 32'h20010005;
  localparam logic [31:0] I_LW_R2       = 32'h8C020000;
  localparam logic [31:0] I_ADD_R4_R2R2 = 32'h00422020;
  localparam logic [31:0] I_ADD_R5_R3R0 = 32'h00602820;
  localparam logic [31:0] I_ORI_R7      = 32'h3407F0F0;

  typedef struct {
    string        nm;
    logic [148:0] data;
  } exp_t;

  exp_t         expQ[$];
  exp_t         curExp;
  logic [148:0] got;
  int           compared   = 0;
  int           mismatched = 0;
  logic [31:0]  pcv;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // Outputs are sampled 1 time unit after each rising edge against the oldest queued expectation.
  always @(posedge clock) begin
    #1;
    if (expQ.size() > 0) begin
      curExp = expQ.pop_front();
      got = {decValid, decProgramCounter, decRsValue, decRtValue, decImmediate, decDestIndex,
             decOpcode, decFunct, decMemRead, decMemWrite, decRegWrite};
      compared++;
      if (got !== curExp.data) begin
        mismatched++;
        $display("FAIL %s: got %h want %h", curExp.nm, got, curExp.data);
      end
    end
  end

  task automatic drive(input logic rst, input logic [31:0] pc, input logic tog, input logic [31:0] ins,
                       input logic jmp, input logic we, input logic [4:0] wi, input logic [31:0] wv);
    @(negedge clock);
    reset               = rst;
    fetchProgramCounter = pc;
    fetchChangedTimes   = tog;
    fetchInstruction    = ins;
    jumpEnabled         = jmp;
    writeEnable         = we;
    writeIndex          = wi;
    writeValue          = wv;
    #1;
  endtask

  task automatic feed(input logic [31:0] pc, input logic tog, input logic [31:0] ins);
    drive(1'b0, pc, tog, ins, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expectBubble(input string nm);
    exp_t e;
    e.nm   = nm;
    e.data = '0;
    expQ.push_back(e);
  endtask

  task automatic expectValid(input string nm, input logic [31:0] pc, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] imm, input logic [4:0] dest,
                             input logic [31:0] ins, input logic mr, input logic mw, input logic rw);
    exp_t e;
    e.nm   = nm;
    e.data = {1'b1, pc, rs, rt, imm, dest, ins[31:26], ins[5:0], mr, mw, rw};
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) begin
      drive(1'b1, 32'h100, 1'b0, I_ADDI_R1_5, 1'b0, 1'b0, 5'd0, 32'd0);
      expectBubble("reset_out");
      compared++;
      if (stallOnDecode !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_stall: got %b want 0", stallOnDecode);
      end
    end
    @(posedge clock);
    #2;
    compared++;
    if ({decValid, decProgramCounter, decRsValue, decRtValue, decImmediate, decDestIndex,
         decOpcode, decFunct, decMemRead, decMemWrite, decRegWrite} !== 149'd0) begin
      mismatched++;
      $display("FAIL reset_state: got valid=%b pc=%h imm=%h dest=%0d want all zero",
               decValid, decProgramCounter, decImmediate, decDestIndex);
    end
  endtask

  task automatic test_priming();
    feed(32'h100, 1'b0, I_ADDI_R1_5);
    expectBubble("priming_bubble");
    feed(32'h100, 1'b0, I_ADDI_R1_5);
    expectValid("addi_first", 32'h100, 32'd0, 32'd0, 32'd5, 5'd1, I_ADDI_R1_5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_decode_table();
    pcv = 32'h200;
    drive(1'b0, pcv, 1'b0, I_ADD_R5_R3R0, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
    expectValid("bypass_rs", pcv, 32'hDEADBEEF, 32'd0, 32'h2820, 5'd5, I_ADD_R5_R3R0, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    drive(1'b0, pcv, 1'b0, 32'h00033020, 1'b0, 1'b1, 5'd0, 32'h12345678);
    expectValid("regfile_rt", pcv, 32'd0, 32'hDEADBEEF, 32'h3020, 5'd6, 32'h00033020, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, I_ORI_R7);
    expectValid("ori_r0_read", pcv, 32'd0, 32'd0, 32'h0000F0F0, 5'd7, I_ORI_R7, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'h306C8001);
    expectValid("andi_zext", pcv, 32'hDEADBEEF, 32'd0, 32'h00008001, 5'd12, 32'h306C8001, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'h3C081234);
    expectValid("lui", pcv, 32'd0, 32'd0, 32'h12340000, 5'd8, 32'h3C081234, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'h2009FFFF);
    expectValid("addi_sext", pcv, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd9, 32'h2009FFFF, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'hAC030004);
    expectValid("sw", pcv, 32'd0, 32'hDEADBEEF, 32'd4, 5'd0, 32'hAC030004, 1'b0, 1'b1, 1'b0);
    pcv += 4;
    feed(pcv, 1'b0, 32'h1060FFFE);
    expectValid("beq", pcv, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFE, 5'd0, 32'h1060FFFE, 1'b0, 1'b0, 1'b0);
    pcv += 4;
    feed(pcv, 1'b0, 32'h08400010);
    expectValid("jump_imm", pcv, 32'd0, 32'd0, 32'h00400010, 5'd0, 32'h08400010, 1'b0, 1'b0, 1'b0);
    pcv += 4;
    feed(pcv, 1'b0, 32'h20000007);
    expectValid("addi_dest0", pcv, 32'd0, 32'd0, 32'd7, 5'd0, 32'h20000007, 1'b0, 1'b0, 1'b0);
    pcv += 4;
    feed(pcv, 1'b0, 32'hFC000000);
    expectValid("unknown_op", pcv, 32'd0, 32'd0, 32'd0, 5'd0, 32'hFC000000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_use();
    pcv = 32'h300;
    feed(pcv, 1'b0, I_LW_R2);
    expectValid("lw", pcv, 32'd0, 32'd0, 32'd0, 5'd2, I_LW_R2, 1'b1, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, I_ADD_R4_R2R2);
    compared++;
    if (stallOnDecode !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_stall_rs: got %b want 1", stallOnDecode);
    end
    expectBubble("lu_bubble");
    drive(1'b0, pcv, 1'b0, I_ADD_R4_R2R2, 1'b0, 1'b1, 5'd2, 32'hCAFE0001);
    compared++;
    if (stallOnDecode !== 1'b0) begin
      mismatched++;
      $display("FAIL lu_stall_clear: got %b want 0", stallOnDecode);
    end
    expectValid("lu_add", pcv, 32'hCAFE0001, 32'hCAFE0001, 32'h2020, 5'd4, I_ADD_R4_R2R2, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'h8C0A0000);
    expectValid("lw_r10", pcv, 32'd0, 32'd0, 32'd0, 5'd10, 32'h8C0A0000, 1'b1, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'h340A0001);
    compared++;
    if (stallOnDecode !== 1'b0) begin
      mismatched++;
      $display("FAIL lu_ori_rt_not_source: got %b want 0", stallOnDecode);
    end
    expectValid("ori_no_hazard", pcv, 32'd0, 32'd0, 32'd1, 5'd10, 32'h340A0001, 1'b0, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, I_LW_R2);
    expectValid("lw_again", pcv, 32'd0, 32'hCAFE0001, 32'd0, 5'd2, I_LW_R2, 1'b1, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, 32'hAC020000);
    compared++;
    if (stallOnDecode !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_stall_sw_rt: got %b want 1", stallOnDecode);
    end
    expectBubble("lu_sw_bubble");
    feed(pcv, 1'b0, 32'hAC020000);
    expectValid("lu_sw", pcv, 32'd0, 32'hCAFE0001, 32'd0, 5'd0, 32'hAC020000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_jump_squash();
    pcv = 32'h400;
    drive(1'b0, pcv, 1'b0, I_ADDI_R1_5, 1'b1, 1'b0, 5'd0, 32'd0);
    compared++;
    if (stallOnDecode !== 1'b0) begin
      mismatched++;
      $display("FAIL jump_stall: got %b want 0", stallOnDecode);
    end
    expectBubble("jump_bubble");
    repeat (2) begin
      pcv += 4;
      feed(pcv, 1'b0, I_ADDI_R1_5);
      expectBubble("wrong_path");
    end
    pcv = 32'h800;
    feed(pcv, 1'b1, I_ADDI_R1_5);
    expectValid("new_path", pcv, 32'd0, 32'd0, 32'd5, 5'd1, I_ADDI_R1_5, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_hazard_with_jump();
    pcv = 32'h804;
    feed(pcv, 1'b1, I_LW_R2);
    expectValid("hj_lw", pcv, 32'd0, 32'hCAFE0001, 32'd0, 5'd2, I_LW_R2, 1'b1, 1'b0, 1'b1);
    pcv += 4;
    drive(1'b0, pcv, 1'b1, I_ADD_R4_R2R2, 1'b1, 1'b0, 5'd0, 32'd0);
    compared++;
    if (stallOnDecode !== 1'b0) begin
      mismatched++;
      $display("FAIL hj_stall: got %b want 0", stallOnDecode);
    end
    expectBubble("hj_bubble");
    feed(pcv, 1'b1, I_ADD_R4_R2R2);
    expectBubble("hj_toggle_flipped");
    pcv = 32'hA00;
    feed(pcv, 1'b0, I_ORI_R7);
    expectValid("hj_new_path", pcv, 32'd0, 32'd0, 32'h0000F0F0, 5'd7, I_ORI_R7, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_stall();
    pcv = 32'hB00;
    feed(pcv, 1'b0, I_LW_R2);
    expectValid("rm_lw", pcv, 32'd0, 32'hCAFE0001, 32'd0, 5'd2, I_LW_R2, 1'b1, 1'b0, 1'b1);
    pcv += 4;
    feed(pcv, 1'b0, I_ADD_R4_R2R2);
    compared++;
    if (stallOnDecode !== 1'b1) begin
      mismatched++;
      $display("FAIL rm_stall_before: got %b want 1", stallOnDecode);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (stallOnDecode !== 1'b0) begin
      mismatched++;
      $display("FAIL rm_stall_dropped: got %b want 0", stallOnDecode);
    end
    expectBubble("rm_reset_out");
    feed(32'hC00, 1'b0, I_ADD_R5_R3R0);
    expectBubble("rm_priming");
    feed(32'hC00, 1'b0, I_ADD_R5_R3R0);
    expectValid("rm_regs_cleared", 32'hC00, 32'd0, 32'd0, 32'h2820, 5'd5, I_ADD_R5_R3R0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef PIPELINE_DECODE_STATS_EN
  task automatic test_stats();
    repeat (2) drive(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    feed(32'h0, 1'b0, I_ADDI_R1_5);
    repeat (3) begin
      feed(32'h10, 1'b0, I_LW_R2);
      feed(32'h14, 1'b0, I_ADD_R4_R2R2);
      feed(32'h14, 1'b0, I_ADD_R4_R2R2);
    end
    drive(1'b0, 32'h18, 1'b0, I_ADDI_R1_5, 1'b1, 1'b0, 5'd0, 32'd0);
    feed(32'h1C, 1'b0, I_ADDI_R1_5);
    feed(32'h40, 1'b1, I_ADDI_R1_5);
    drive(1'b0, 32'h44, 1'b1, I_ADDI_R1_5, 1'b1, 1'b0, 5'd0, 32'd0);
    feed(32'h48, 1'b1, I_ADDI_R1_5);
    feed(32'h80, 1'b0, I_ADDI_R1_5);
    compared++;
    if (stallCount !== 32'd3) begin
      mismatched++;
      $display("FAIL stats_stall: got %0d want 3", stallCount);
    end
    compared++;
    if (squashCount !== 32'd4) begin
      mismatched++;
      $display("FAIL stats_squash: got %0d want 4", squashCount);
    end
    drive(1'b1, 32'h0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    feed(32'h0, 1'b0, 32'd0);
    compared++;
    if (stallCount !== 32'd0 || squashCount !== 32'd0) begin
      mismatched++;
      $display("FAIL stats_reset: got %0d/%0d want 0/0", stallCount, squashCount);
    end
  endtask
`endif

  initial begin
    reset               = 1'b1;
    fetchProgramCounter = '0;
    fetchChangedTimes   = 1'b0;
    fetchInstruction    = '0;
    jumpEnabled         = 1'b0;
    writeEnable         = 1'b0;
    writeIndex          = '0;
    writeValue          = '0;

    test_reset();
    test_priming();
    test_decode_table();
    test_load_use();
    test_jump_squash();
    test_hazard_with_jump();
    test_reset_mid_stall();
`ifdef PIPELINE_DECODE_STATS_EN
    test_stats();
`endif

    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge clock);
    #2;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
